// File: rtl/blink_memarb.sv
// Blink physical memory bus arbiter: Z80 pass-through with LCD plane
// fetches slotted into idle cycles and a WAIT stall when the LCD starves.
module blink_memarb #(
    parameter int STARVE = 6
) (
    input  logic        mck,
    input  logic        rin,
    input  logic [21:0] cpu_ma,
    input  logic        cpu_mrq_n,
    input  logic        cpu_rd_n,
    input  logic        lcd_req,
    input  logic [21:0] lcd_addr,
    input  logic [7:0]  mem_d,
    output logic [21:0] ma,
    output logic        ipce_n,
    output logic        irce_n,
    output logic        se1_n,
    output logic        se2_n,
    output logic        se3_n,
    output logic        roe_n,
    output logic        wrb_n,
    output logic        lcd_vld,
    output logic [7:0]  lcd_data,
    output logic        cpu_wait_n
);

    localparam int SW = $clog2(STARVE + 1);

    typedef enum logic [1:0] {
        IDLE,
        CPU,
        LADR,
        LDAT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] starve;
    logic          lcd_own;
    logic          starved;
    logic          preempt;
    logic          active;

    assign lcd_own = (state == LADR) || (state == LDAT);
    assign starved = (starve == SW'(STARVE));
    // Only stall on a read or the cycle MREQ rises; a write strobe is never cut.
    assign preempt = (state == CPU) && lcd_req && starved &&
                     (cpu_mrq_n || !cpu_rd_n);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!cpu_mrq_n)
                    state_nx = CPU;
                else if (lcd_req)
                    state_nx = LADR;
            end
            CPU: begin
                if (cpu_mrq_n)
                    state_nx = lcd_req ? LADR : IDLE;
                else if (preempt)
                    state_nx = LADR;
            end
            LADR: state_nx = LDAT;
            LDAT: state_nx = cpu_mrq_n ? IDLE : CPU;
        endcase
    end

    always_ff @(posedge mck) begin
        if (rin) begin
            state      <= IDLE;
            starve     <= '0;
            lcd_data   <= 8'h00;
            lcd_vld    <= 1'b0;
            cpu_wait_n <= 1'b1;
        end else begin
            state   <= state_nx;
            lcd_vld <= (state == LDAT);
            if (state == LDAT)
                lcd_data <= mem_d;
            if (!lcd_req || state_nx == LADR)
                starve <= '0;
            else if (!lcd_own && !starved)
                starve <= starve + SW'(1);
            if (preempt)
                cpu_wait_n <= 1'b0;
            else if (!lcd_own)
                cpu_wait_n <= 1'b1;
        end
    end

    assign ma     = lcd_own ? lcd_addr : cpu_ma;
    assign roe_n  = lcd_own ? 1'b0 : (cpu_mrq_n | cpu_rd_n);
    assign wrb_n  = lcd_own ? 1'b1 : (cpu_mrq_n | !cpu_rd_n);
    assign active = lcd_own | !cpu_mrq_n;

    always_comb begin
        ipce_n = 1'b1;
        irce_n = 1'b1;
        se1_n  = 1'b1;
        se2_n  = 1'b1;
        se3_n  = 1'b1;
        if (active) begin
            unique case (1'b1)
                ma[21:19] == 3'b000: ipce_n = 1'b0;
                ma[21:19] == 3'b001: irce_n = 1'b0;
                ma[21:20] == 2'b01:  se1_n  = 1'b0;
                ma[21:20] == 2'b10:  se2_n  = 1'b0;
                ma[21:20] == 2'b11:  se3_n  = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_memarb.sv
// Bench for blink_memarb: decode vector table plus LCD fetch sequences
// whose returned data is checked against a scoreboard queue.
module tb_blink_memarb;

    localparam int STARVE = 6;

    logic        mck = 1'b0;
    logic        rin;
    logic [21:0] cpu_ma;
    logic        cpu_mrq_n;
    logic        cpu_rd_n;
    logic        lcd_req;
    logic [21:0] lcd_addr;
    logic [7:0]  mem_d;
    logic [21:0] ma;
    logic        ipce_n, irce_n, se1_n, se2_n, se3_n;
    logic        roe_n, wrb_n;
    logic        lcd_vld;
    logic [7:0]  lcd_data;
    logic        cpu_wait_n;

    int nvec = 0;
    int nerr = 0;
    int nvld = 0;
    int npush = 0;
    logic [7:0] sb[$];

    blink_memarb #(.STARVE(STARVE)) dut (
        .mck(mck), .rin(rin), .cpu_ma(cpu_ma), .cpu_mrq_n(cpu_mrq_n),
        .cpu_rd_n(cpu_rd_n), .lcd_req(lcd_req), .lcd_addr(lcd_addr),
        .mem_d(mem_d), .ma(ma), .ipce_n(ipce_n), .irce_n(irce_n),
        .se1_n(se1_n), .se2_n(se2_n), .se3_n(se3_n), .roe_n(roe_n),
        .wrb_n(wrb_n), .lcd_vld(lcd_vld), .lcd_data(lcd_data),
        .cpu_wait_n(cpu_wait_n)
    );

    always #5 mck = ~mck;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mck);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        sb.push_back(d);
        npush++;
    endtask

    always @(negedge mck) begin
        if (lcd_vld === 1'b1) begin
            nvld++;
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL sb_unexpected: got vld data %0h want none",
                         lcd_data);
            end else begin
                chk("sb_data", {24'h0, lcd_data}, {24'h0, sb.pop_front()});
            end
        end
    end

    typedef struct {
        logic [21:0] a;
        logic        mrq_n;
        logic        rd_n;
        logic [4:0]  en;
        logic        roe;
        logic        wrb;
    } vec_t;

    vec_t vt[9];

    function automatic logic [4:0] ens();
        return {ipce_n, irce_n, se1_n, se2_n, se3_n};
    endfunction

    initial begin
        vt[0] = '{22'h000000, 1'b0, 1'b0, 5'b01111, 1'b0, 1'b1};
        vt[1] = '{22'h080000, 1'b0, 1'b0, 5'b10111, 1'b0, 1'b1};
        vt[2] = '{22'h100000, 1'b0, 1'b0, 5'b11011, 1'b0, 1'b1};
        vt[3] = '{22'h200000, 1'b0, 1'b0, 5'b11101, 1'b0, 1'b1};
        vt[4] = '{22'h300000, 1'b0, 1'b0, 5'b11110, 1'b0, 1'b1};
        vt[5] = '{22'h07FFFF, 1'b0, 1'b0, 5'b01111, 1'b0, 1'b1};
        vt[6] = '{22'h0FFFFF, 1'b0, 1'b0, 5'b10111, 1'b0, 1'b1};
        vt[7] = '{22'h3FFFFF, 1'b0, 1'b1, 5'b11110, 1'b1, 1'b0};
        vt[8] = '{22'h1FFFFF, 1'b1, 1'b1, 5'b11111, 1'b1, 1'b1};

        rin = 1'b1;
        cpu_ma = '0;
        cpu_mrq_n = 1'b1;
        cpu_rd_n = 1'b1;
        lcd_req = 1'b0;
        lcd_addr = '0;
        mem_d = 8'h00;

        // reset
        tick();
        #3;
        chk("rst_vld", lcd_vld, 1'b0);
        chk("rst_wait", cpu_wait_n, 1'b1);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_en", ens(), 5'b11111);
        chk("rst_strb", {roe_n, wrb_n}, 2'b11);
        cpu_mrq_n = 1'b0;
        cpu_ma = 22'h080000;
        tick();
        rin = 1'b0;
        cpu_rd_n = 1'b0;
        #3;
        chk("rst_post_vld", lcd_vld, 1'b0);
        chk("rst_post_wait", cpu_wait_n, 1'b1);
        chk("rst_post_en", ens(), 5'b10111);
        chk("rst_post_roe", roe_n, 1'b0);

        // decode sweep
        for (int i = 0; i < 9; i++) begin
            tick();
            cpu_ma = vt[i].a;
            cpu_mrq_n = vt[i].mrq_n;
            cpu_rd_n = vt[i].rd_n;
            #3;
            chk($sformatf("dec%0d_en", i), ens(), vt[i].en);
            chk($sformatf("dec%0d_strb", i), {roe_n, wrb_n},
                {vt[i].roe, vt[i].wrb});
            chk($sformatf("dec%0d_ma", i), ma, vt[i].a);
        end
        tick();
        tick();

        // idle-bus LCD fetch
        lcd_req = 1'b1;
        lcd_addr = 22'h0BF800;
        mem_d = 8'hA5;
        push(8'hA5);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 3)
                lcd_req = 1'b0;
            #3;
            if (c <= 2) begin
                chk($sformatf("idl_ma%0d", c), ma, 22'h0BF800);
                chk($sformatf("idl_en%0d", c), ens(), 5'b10111);
                chk($sformatf("idl_roe%0d", c), roe_n, 1'b0);
            end
            chk($sformatf("idl_vld%0d", c), lcd_vld, c == 3);
            chk($sformatf("idl_wait%0d", c), cpu_wait_n, 1'b1);
        end
        chk("idl_hold", lcd_data, 8'hA5);

        // starvation under continuous CPU reads
        cpu_mrq_n = 1'b0;
        cpu_rd_n = 1'b0;
        cpu_ma = 22'h000100;
        lcd_req = 1'b1;
        lcd_addr = 22'h0BF810;
        mem_d = 8'h3C;
        push(8'h3C);
        for (int c = 1; c <= STARVE + 6; c++) begin
            tick();
            #3;
            chk($sformatf("stv_wait%0d", c), cpu_wait_n,
                !(c >= STARVE + 1 && c <= STARVE + 3));
            chk($sformatf("stv_vld%0d", c), lcd_vld, c == STARVE + 3);
            if (c == STARVE + 1 || c == STARVE + 2)
                chk($sformatf("stv_ma%0d", c), ma, 22'h0BF810);
            if (c == STARVE + 3)
                lcd_req = 1'b0;
        end
        cpu_mrq_n = 1'b1;
        cpu_rd_n = 1'b1;
        tick();
        tick();

        // write protection
        cpu_mrq_n = 1'b0;
        cpu_rd_n = 1'b1;
        cpu_ma = 22'h100000;
        lcd_req = 1'b1;
        lcd_addr = 22'h0BF820;
        mem_d = 8'h5A;
        push(8'h5A);
        for (int c = 1; c <= 10; c++) begin
            tick();
            #3;
            chk($sformatf("wp_wrb%0d", c), wrb_n, 1'b0);
            chk($sformatf("wp_ma%0d", c), ma, 22'h100000);
        end
        cpu_mrq_n = 1'b0;
        cpu_mrq_n = 1'b1;
        tick();
        #3;
        chk("wp_ladr_ma", ma, 22'h0BF820);
        chk("wp_ladr_wrb", wrb_n, 1'b1);
        tick();
        #3;
        chk("wp_ldat_vld", lcd_vld, 1'b0);
        tick();
        lcd_req = 1'b0;
        #3;
        chk("wp_vld", lcd_vld, 1'b1);
        tick();
        #3;
        chk("wp_wait_after", cpu_wait_n, 1'b1);
        tick();

        // simultaneous request: CPU first
        cpu_mrq_n = 1'b0;
        cpu_rd_n = 1'b0;
        cpu_ma = 22'h200000;
        lcd_req = 1'b1;
        lcd_addr = 22'h0BF830;
        mem_d = 8'h77;
        push(8'h77);
        tick();
        cpu_mrq_n = 1'b1;
        cpu_ma = 22'h200000;
        #3;
        chk("sim_cpu_ma", ma, 22'h200000);
        cpu_mrq_n = 1'b0;
        #1;
        chk("sim_cpu_en", ens(), 5'b11101);
        cpu_mrq_n = 1'b1;
        cpu_rd_n = 1'b1;
        tick();
        #3;
        chk("sim_ladr_ma", ma, 22'h0BF830);
        tick();
        #3;
        chk("sim_wait", cpu_wait_n, 1'b1);
        tick();
        lcd_req = 1'b0;
        #3;
        chk("sim_vld", lcd_vld, 1'b1);
        tick();

        // reset during LADR aborts the fetch
        lcd_req = 1'b1;
        lcd_addr = 22'h0BF840;
        mem_d = 8'hE1;
        tick();
        rin = 1'b1;
        #3;
        chk("mfr_ladr_ma", ma, 22'h0BF840);
        tick();
        rin = 1'b0;
        push(8'hE1);
        #3;
        chk("mfr_vld0", lcd_vld, 1'b0);
        chk("mfr_data0", lcd_data, 8'h00);
        for (int c = 1; c <= 3; c++) begin
            tick();
            #3;
            chk($sformatf("mfr_vld%0d", c), lcd_vld, c == 3);
            if (c == 3)
                lcd_req = 1'b0;
        end
        tick();
        tick();

        chk("sb_empty", sb.size(), 0);
        chk("vld_count", nvld, npush);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
